fracturable_mac_pipelined: RTL

//  Pipelined, width-parametrised fracturable multiply-accumulate for the PIRDSP MAC models.

---
 rtl/fracturable_mac_pipelined.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fracturable_mac_pipelined.sv
// fracturable_mac_pipelined
//   Pipelined fracturable multiply-accumulate. FULL mode forms one W x W
//   product; SPLIT mode forms two independent lane products (LO_W x LO_W and
//   HI_W x HI_W, HI_W = W-LO_W) with no cross-lane carry. Each operand is
//   signed or unsigned under control of a_sign/b_sign. Each lane owns an
//   ACC_W = 2*W+G accumulator with a sticky overflow flag. Streaming, no
//   backpressure; a valid beat at edge N produces out_valid at edge N+3.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid            operand beat valid
//   a, b                operands (W bits)
//   a_sign, b_sign      1: operand (or each operand lane) is two's complement
//   split               0: FULL, 1: SPLIT
//   acc_en              1: accumulate, 0: load accumulator with product
//   out_valid           result beat valid
//   acc_lo, acc_hi      FULL: full accumulator / 0; SPLIT: low / high lane
//   ovf_lo, ovf_hi      sticky overflow of the matching accumulator
module fracturable_mac_pipelined #(
    parameter int W    = 9,
    parameter int LO_W = 4,
    parameter int G    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic                 split,
    input  logic                 acc_en,
    output logic                 out_valid,
    output logic [2*W+G-1:0]     acc_lo,
    output logic [2*W+G-1:0]     acc_hi,
    output logic                 ovf_lo,
    output logic                 ovf_hi
);

    localparam int HI_W  = W - LO_W;
    localparam int ACC_W = 2*W + G;

    // Overflow of a modulo-2^ACC_W addition: for signed lanes both addends
    // share a sign and the sum sign differs; for unsigned lanes a carry out.
    function automatic logic add_ovf(input logic [ACC_W-1:0] x,
                                     input logic [ACC_W-1:0] y,
                                     input logic             sgn);
        logic [ACC_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (sgn)
            return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
        else
            return s[ACC_W];
    endfunction

    // ---------------- S1: operand registers ----------------
    logic [W-1:0] a_p0, b_p0;
    logic         a_sign_p0, b_sign_p0, split_p0, acc_en_p0, vld_p0;

    always_ff @(posedge clk) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= in_valid;
    end

    always_ff @(posedge clk) begin
        a_p0      <= a;
        b_p0      <= b;
        a_sign_p0 <= a_sign;
        b_sign_p0 <= b_sign;
        split_p0  <= split;
        acc_en_p0 <= acc_en;
    end

    // ---------------- S2: lane products ----------------
    // Operands are extended to the truncated product width, so the low 2*w
    // bits of the modular product equal the truncated exact product.
    logic signed [2*W-1:0]    fa_x, fb_x, f_prod;
    logic signed [2*LO_W-1:0] la_x, lb_x, l_prod;
    logic signed [2*HI_W-1:0] ha_x, hb_x, h_prod;
    logic                     sg_p0;
    logic signed [ACC_W-1:0]  prod_lo_d, prod_hi_d;

    always_comb begin
        sg_p0  = a_sign_p0 | b_sign_p0;
        fa_x   = {{W{a_p0[W-1] & a_sign_p0}}, a_p0};
        fb_x   = {{W{b_p0[W-1] & b_sign_p0}}, b_p0};
        la_x   = {{LO_W{a_p0[LO_W-1] & a_sign_p0}}, a_p0[LO_W-1:0]};
        lb_x   = {{LO_W{b_p0[LO_W-1] & b_sign_p0}}, b_p0[LO_W-1:0]};
        ha_x   = {{HI_W{a_p0[W-1] & a_sign_p0}}, a_p0[W-1:LO_W]};
        hb_x   = {{HI_W{b_p0[W-1] & b_sign_p0}}, b_p0[W-1:LO_W]};
        f_prod = fa_x * fb_x;
        l_prod = la_x * lb_x;
        h_prod = ha_x * hb_x;
        if (split_p0) begin
            prod_lo_d = {{(ACC_W-2*LO_W){sg_p0 & l_prod[2*LO_W-1]}}, l_prod};
            prod_hi_d = {{(ACC_W-2*HI_W){sg_p0 & h_prod[2*HI_W-1]}}, h_prod};
        end else begin
            prod_lo_d = {{G{sg_p0 & f_prod[2*W-1]}}, f_prod};
            prod_hi_d = '0;
        end
    end

    logic signed [ACC_W-1:0] prod_lo_p1, prod_hi_p1;
    logic                    a_sign_p1, b_sign_p1, split_p1, acc_en_p1, vld_p1;

    always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        prod_lo_p1 <= prod_lo_d;
        prod_hi_p1 <= prod_hi_d;
        a_sign_p1  <= a_sign_p0;
        b_sign_p1  <= b_sign_p0;
        split_p1   <= split_p0;
        acc_en_p1  <= acc_en_p0;
    end

    // ---------------- S3: accumulate ----------------
    logic signed [ACC_W-1:0] acc_lo_p2, acc_hi_p2;
    logic                    ovf_lo_p2, ovf_hi_p2, vld_p2;
    logic                    have_prev, prev_split, prev_a_sign, prev_b_sign;
    logic                    load_p1, sg_p1;

    // A change of lane layout or signedness makes the old sum meaningless,
    // so such a beat restarts the accumulator regardless of acc_en.
    always_comb begin
        sg_p1   = a_sign_p1 | b_sign_p1;
        load_p1 = !acc_en_p1 || !have_prev || (split_p1 != prev_split) ||
                  (a_sign_p1 != prev_a_sign) || (b_sign_p1 != prev_b_sign);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            have_prev <= 1'b0;
            acc_lo_p2 <= '0;
            acc_hi_p2 <= '0;
            ovf_lo_p2 <= 1'b0;
            ovf_hi_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                have_prev <= 1'b1;
                if (load_p1) begin
                    acc_lo_p2 <= prod_lo_p1;
                    ovf_lo_p2 <= 1'b0;
                end else begin
                    acc_lo_p2 <= acc_lo_p2 + prod_lo_p1;
                    ovf_lo_p2 <= ovf_lo_p2 | add_ovf(acc_lo_p2, prod_lo_p1, sg_p1);
                end
                if (!split_p1) begin
                    acc_hi_p2 <= '0;
                    ovf_hi_p2 <= 1'b0;
                end else if (load_p1) begin
                    acc_hi_p2 <= prod_hi_p1;
                    ovf_hi_p2 <= 1'b0;
                end else begin
                    acc_hi_p2 <= acc_hi_p2 + prod_hi_p1;
                    ovf_hi_p2 <= ovf_hi_p2 | add_ovf(acc_hi_p2, prod_hi_p1, sg_p1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            prev_split  <= split_p1;
            prev_a_sign <= a_sign_p1;
            prev_b_sign <= b_sign_p1;
        end
    end

    // ---------------- Output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            acc_lo    <= '0;
            acc_hi    <= '0;
            ovf_lo    <= 1'b0;
            ovf_hi    <= 1'b0;
        end else begin
            out_valid <= vld_p2;
            if (vld_p2) begin
                acc_lo <= acc_lo_p2;
                acc_hi <= acc_hi_p2;
                ovf_lo <= ovf_lo_p2;
                ovf_hi <= ovf_hi_p2;
            end
        end
    end

endmodule
